// File: rtl/iterative_divider_pkg.sv
// rtl/iterative_divider_pkg.sv - shared types and sizing helpers for the iterative divider
// Feature macro: DIVIDER_SIGNED_EN (two's complement operands when defined)
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter wide enough to hold the full iteration count
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/iterative_divider_if.sv
// rtl/iterative_divider_if.sv - operand/result handshake bundle for the iterative divider
interface iterative_divider_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/iterative_divider_step.sv
// rtl/iterative_divider_step.sv - one combinational restoring-division iteration
module divider_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Partial remainder is always below the divisor, so the MSB of the
  // WIDTH+1-bit difference is a reliable sign bit.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - shared restoring divider, one quotient bit per clock
// Feature macro: DIVIDER_SIGNED_EN (two's complement operands when defined)
module iterative_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  iterative_divider_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q;
  // Dividend shifts out of the top while quotient bits shift in at the bottom
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_fin;
  logic             last_iter;
  logic             accept;
  logic             zero_div;

  logic [WIDTH-1:0] dvd_load;
  logic [WIDTH-1:0] dvs_load;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .divisor (dvs_q),
    .bit_in  (dvd_q[WIDTH-1]),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign accept    = (state == IDLE) && bus.in_valid;
  assign zero_div  = (bus.divisor == '0);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign q_fin     = {dvd_q[WIDTH-2:0], step_q};

`ifdef DIVIDER_SIGNED_EN
  logic q_neg;
  logic r_neg;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  // Work on magnitudes; signs are reapplied as the result is registered
  always_comb begin
    dvd_load = mag(bus.dividend);
    dvs_load = mag(bus.divisor);
    q_out    = q_neg ? (~q_fin + WIDTH'(1)) : q_fin;
    r_out    = r_neg ? (~step_rem + WIDTH'(1)) : step_rem;
  end

  // Result signs captured with the operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (accept) begin
      q_neg <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      r_neg <= bus.dividend[WIDTH-1];
    end
  end
`else
  // Unsigned operands pass straight through
  always_comb begin
    dvd_load = bus.dividend;
    dvs_load = bus.divisor;
    q_out    = q_fin;
    r_out    = step_rem;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; a zero divisor skips straight to the result
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = zero_div ? DONE : CALC;
      CALC: if (last_iter)    state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            cnt   <= '0;
            rem_q <= '0;
            dvd_q <= dvd_load;
            dvs_q <= dvs_load;
            if (zero_div) begin
              quotient_q  <= '1;
              remainder_q <= bus.dividend;
              dbz_q       <= 1'b1;
            end
          end
        end
        CALC: begin
          rem_q <= step_rem;
          dvd_q <= q_fin;
          cnt   <= cnt + CNT_W'(1);
          if (last_iter) begin
            cnt         <= '0;
            quotient_q  <= q_out;
            remainder_q <= r_out;
            dbz_q       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_iterative_divider.sv
// tb/tb_iterative_divider.sv - self-checking bench for iterative_divider
module tb_iterative_divider;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  iterative_divider_if #(.WIDTH(W)) dif ();

  iterative_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division on the operand values
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, q, r;
    logic [W-1:0] qv, rv;
    if (b == '0) return {1'b1, {W{1'b1}}, a};
`ifdef DIVIDER_SIGNED_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
`else
    sa = int'(a);
    sb = int'(b);
`endif
    q  = sa / sb;
    r  = sa % sb;
    qv = q[W-1:0];
    rv = r[W-1:0];
    return {1'b0, qv, rv};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, wait with a bound, check, hold, handshake
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [2*W:0] e;
    logic [W-1:0] eq, er;
    int lat;
    e  = model(a, b);
    eq = e[2*W-1:W];
    er = e[W-1:0];
    @(negedge clk);
    check("in_ready_before", 32'(dif.in_ready), 32'd1);
    dif.in_valid = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    dif.dividend = W'($urandom);
    dif.divisor  = W'($urandom);
    lat = 1;
    @(negedge clk);
    while (!dif.out_valid && lat < 40) begin
      check("in_ready_busy", 32'(dif.in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), (b == '0) ? 32'd1 : 32'(W + 1));
    check("quotient", 32'(dif.quotient), 32'(eq));
    check("remainder", 32'(dif.remainder), 32'(er));
    check("div_by_zero", 32'(dif.div_by_zero), 32'(e[2*W]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(dif.out_valid), 32'd1);
      check("hold_in_ready", 32'(dif.in_ready), 32'd0);
      check("hold_quotient", 32'(dif.quotient), 32'(eq));
      check("hold_remainder", 32'(dif.remainder), 32'(er));
    end
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.out_ready = 1'b0;
    @(negedge clk);
    check("in_ready_after", 32'(dif.in_ready), 32'd1);
    check("valid_after", 32'(dif.out_valid), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    vecs          = 0;
    errs          = 0;
    rst_n         = 1'b0;
    dif.in_valid  = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    dif.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(dif.in_ready), 32'd1);
    check("rst_out_valid", 32'(dif.out_valid), 32'd0);
    check("rst_quotient", 32'(dif.quotient), 32'd0);
    check("rst_remainder", 32'(dif.remainder), 32'd0);
    check("rst_dbz", 32'(dif.div_by_zero), 32'd0);
    rst_n = 1'b1;

    run_op(8'd100, 8'd7, 0);
    run_op(8'd55, 8'd0, 0);
    run_op(8'h9C, 8'd7, 0);
    run_op(8'h80, 8'hFF, 0);
    run_op(8'd200, 8'd3, 5);
    run_op(8'd255, 8'd1, 1);
    run_op(8'd7, 8'd200, 0);

    // Reset during the fourth iteration cycle discards the operation
    @(negedge clk);
    dif.in_valid = 1'b1;
    dif.dividend = 8'd100;
    dif.divisor  = 8'd7;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(dif.in_ready), 32'd1);
    check("midrst_out_valid", 32'(dif.out_valid), 32'd0);
    check("midrst_quotient", 32'(dif.quotient), 32'd0);
    check("midrst_remainder", 32'(dif.remainder), 32'd0);
    check("midrst_dbz", 32'(dif.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("midrst_no_valid", 32'(dif.out_valid), 32'd0);
    end
    run_op(8'd9, 8'd3, 0);

    for (int n = 0; n < 25; n++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
